// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment definitions.
// Segment bit order, blank pattern and hex-to-segment table for common-anode
// (active-low) displays.
package seg7_pkg;

   // Segment vector, MSB first: {g,f,e,d,c,b,a}; a 0 lights the segment.
   typedef struct packed {
      logic g;
      logic f;
      logic e;
      logic d;
      logic c;
      logic b;
      logic a;
   } seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Hex digit to active-low segment pattern; 10 renders "A".
   function automatic seg_t hex_to_seg(input logic [3:0] v);
      seg_t s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         4'hF:    s = 7'h0E;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Counter width for a modulus n, never narrower than one bit.
   function automatic int min1_clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: digit/carry inputs from the counter chain and the
// multiplexed display pins. master = counter side, slave = display driver.
interface seg7_scan_display_if #(
   parameter int NDIG = 4
);
   logic [4*NDIG-1:0] digits;
   logic [NDIG-1:0]   dp_in;
   logic              blank_lz;
   logic [NDIG-1:0]   carry_in;
   logic [NDIG-1:0]   an_n;
   logic [6:0]        seg_n;
   logic              dp_n;
   logic              carry_led;

   modport master (
      output digits, dp_in, blank_lz, carry_in,
      input  an_n, seg_n, dp_n, carry_led
   );

   modport slave (
      input  digits, dp_in, blank_lz, carry_in,
      output an_n, seg_n, dp_n, carry_led
   );
endinterface

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// hex_to_seg7: combinational 4-bit value to active-low segment decoder.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output seg_t       seg_n
);

   // Table lookup shared with every other display block.
   always_comb seg_n = hex_to_seg(hex);

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: scans NDIG digits onto a common-anode display.
// Digits are snapshotted once per frame so a frame never mixes old and new
// values; carry pulses are stretched into a visible LED.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int NDIG     = 4,
   parameter int SCAN_DIV = 50000,
   parameter int STRETCH  = 5000000
) (
   input logic                clk,
   input logic                rst,
   seg7_scan_display_if.slave bus
);

   localparam int PW = min1_clog2(SCAN_DIV);
   localparam int IW = min1_clog2(NDIG);
   localparam int SW = min1_clog2(STRETCH);

   localparam logic [PW-1:0] PRESC_ZERO   = {PW{1'b0}};
   localparam logic [PW-1:0] PRESC_ONE    = PW'(1);
   localparam logic [PW-1:0] PRESC_LAST   = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_ZERO     = {IW{1'b0}};
   localparam logic [IW-1:0] IDX_ONE      = IW'(1);
   localparam logic [IW-1:0] IDX_LAST     = IW'(NDIG - 1);
   localparam logic [SW-1:0] STRETCH_ZERO = {SW{1'b0}};
   localparam logic [SW-1:0] STRETCH_ONE  = SW'(1);
   localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH - 1);

   logic [PW-1:0]     presc_r;
   logic [IW-1:0]     idx_r;
   logic [4*NDIG-1:0] snap_dig_r;
   logic [NDIG-1:0]   snap_dp_r;
   logic [SW-1:0]     stretch_r;
   logic [NDIG-1:0]   an_n_r;
   seg_t              seg_n_r;
   logic              dp_n_r;
   logic              carry_led_r;

   logic              tick_s;
   logic              frame_start_s;
   logic [NDIG-1:0]   hit_s;
   logic [NDIG-1:0]   lz_s;
   logic [3:0]        sel_dig_s;
   logic              sel_dp_s;
   logic              sel_lz_s;
   logic              blank_s;
   logic [NDIG-1:0]   an_n_s;
   seg_t              hex_seg_s;

   assign tick_s        = (presc_r == PRESC_LAST);
   assign frame_start_s = tick_s && (idx_r == IDX_LAST);

   // Prescaler: free-running 0..SCAN_DIV-1 dwell counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         presc_r <= PRESC_ZERO;
      else if (tick_s) presc_r <= PRESC_ZERO;
      else             presc_r <= presc_r + PRESC_ONE;
   end

   // Digit index: advances once per dwell period and wraps after the MSD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  idx_r <= IDX_ZERO;
      else if (frame_start_s)   idx_r <= IDX_ZERO;
      else if (tick_s)          idx_r <= idx_r + IDX_ONE;
      else                      idx_r <= idx_r;
   end

   // Snapshot: capture live digits and decimal points only at frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_dig_r <= {(4*NDIG){1'b0}};
         snap_dp_r  <= {NDIG{1'b0}};
      end else if (frame_start_s) begin
         snap_dig_r <= bus.digits;
         snap_dp_r  <= bus.dp_in;
      end else begin
         snap_dig_r <= snap_dig_r;
         snap_dp_r  <= snap_dp_r;
      end
   end

   // One-hot decode of the digit currently being scanned.
   always_comb begin
      hit_s = {NDIG{1'b0}};
      for (int i = 0; i < NDIG; i++) hit_s[i] = (idx_r == IW'(i));
   end

   // Leading-zero map: bit i set when snapshot digits i..NDIG-1 are all zero;
   // digit 0 always stays visible.
   always_comb begin : lz_chain
      logic all_zero_v;
      all_zero_v = 1'b1;
      lz_s       = {NDIG{1'b0}};
      for (int i = NDIG - 1; i >= 0; i--) begin
         all_zero_v = all_zero_v & (snap_dig_r[4*i +: 4] == 4'h0);
         lz_s[i]    = all_zero_v;
      end
      lz_s[0] = 1'b0;
   end

   // Mux the scanned digit's value, decimal point and blank flag out of the snapshot.
   always_comb begin
      sel_dig_s = 4'h0;
      sel_dp_s  = 1'b0;
      sel_lz_s  = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         sel_dig_s = sel_dig_s | (snap_dig_r[4*i +: 4] & {4{hit_s[i]}});
         sel_dp_s  = sel_dp_s | (snap_dp_r[i] & hit_s[i]);
         sel_lz_s  = sel_lz_s | (lz_s[i] & hit_s[i]);
      end
   end

   assign blank_s = bus.blank_lz & sel_lz_s;
   // All anodes off on the first dwell cycle so the previous digit never ghosts.
   assign an_n_s  = (presc_r == PRESC_ZERO) ? {NDIG{1'b1}} : ~hit_s;

   hex_to_seg7 u_hex (
      .hex   (sel_dig_s),
      .seg_n (hex_seg_s)
   );

   // Output registers: blanked digits keep their anode so duty stays uniform.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_n_r  <= {NDIG{1'b1}};
         seg_n_r <= SEG_BLANK;
         dp_n_r  <= 1'b1;
      end else begin
         an_n_r  <= an_n_s;
         seg_n_r <= blank_s ? SEG_BLANK : hex_seg_s;
         dp_n_r  <= blank_s ? 1'b1 : ~sel_dp_s;
      end
   end

   // Carry stretch: any pulse (re)loads the counter; LED drops after it drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stretch_r   <= STRETCH_ZERO;
         carry_led_r <= 1'b0;
      end else if (|bus.carry_in) begin
         stretch_r   <= STRETCH_LOAD;
         carry_led_r <= 1'b1;
      end else if (stretch_r != STRETCH_ZERO) begin
         stretch_r   <= stretch_r - STRETCH_ONE;
         carry_led_r <= 1'b1;
      end else begin
         stretch_r   <= STRETCH_ZERO;
         carry_led_r <= 1'b0;
      end
   end

   assign bus.an_n      = an_n_r;
   assign bus.seg_n     = seg_n_r;
   assign bus.dp_n      = dp_n_r;
   assign bus.carry_led = carry_led_r;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: randomized self-checking bench. The reference model
// derives each cycle's expected outputs from the elapsed cycle count since
// reset and the input history recorded at every clock edge.
module tb_seg7_scan_display;

   localparam int ND = 4;
   localparam int SD = 4;
   localparam int ST = 8;
   localparam int L  = ND * SD;
   localparam int HN = 4096;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   seg7_scan_display_if #(.NDIG(ND)) m_if ();
   seg7_scan_display_if #(.NDIG(1))  e_if ();

   seg7_scan_display #(.NDIG(ND), .SCAN_DIV(SD), .STRETCH(ST)) dut (
      .clk (clk), .rst (rst), .bus (m_if)
   );

   seg7_scan_display #(.NDIG(1), .SCAN_DIV(2), .STRETCH(1)) dut_e (
      .clk (clk), .rst (rst), .bus (e_if)
   );

   // Input history, indexed by clock-edge number since reset release.
   int          m_n, e_n;
   logic [15:0] h_dig [HN];
   logic [3:0]  h_dp  [HN];
   logic        h_blz [HN];
   logic        h_car [HN];
   logic [3:0]  he_dig [HN];
   logic        he_dp  [HN];
   logic        he_car [HN];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_n <= 0;
         e_n <= 0;
      end else begin
         m_n <= m_n + 1;
         e_n <= e_n + 1;
         if (m_n < HN - 1) begin
            h_dig[m_n + 1] <= m_if.digits;
            h_dp[m_n + 1]  <= m_if.dp_in;
            h_blz[m_n + 1] <= m_if.blank_lz;
            h_car[m_n + 1] <= |m_if.carry_in;
         end
         if (e_n < HN - 1) begin
            he_dig[e_n + 1] <= e_if.digits;
            he_dp[e_n + 1]  <= e_if.dp_in[0];
            he_car[e_n + 1] <= e_if.carry_in[0];
         end
      end
   end

   // Expected {an_n, seg_n, dp_n, carry_led} after edge n (n >= 1) of the main DUT.
   function automatic logic [12:0] exp_main(input int n);
      int s, presc, idx, f;
      logic [15:0] snap;
      logic [3:0]  sdp, nib, an;
      logic [6:0]  seg;
      logic        blank, dp, led;
      s     = n - 1;
      presc = s % SD;
      idx   = (s / SD) % ND;
      f     = s / L;
      snap  = (f == 0) ? 16'h0000 : h_dig[f * L];
      sdp   = (f == 0) ? 4'h0 : h_dp[f * L];
      nib   = 4'(snap >> (4 * idx));
      blank = h_blz[n] && (idx >= 1) && ((snap >> (4 * idx)) == 16'h0000);
      an    = (presc == 0) ? 4'hF : ~(4'b0001 << idx);
      seg   = blank ? 7'h7F : SEG_TAB[nib];
      dp    = blank ? 1'b1 : ~sdp[idx];
      led   = 1'b0;
      for (int k = 0; k < ST; k++)
         if ((n - k >= 1) && h_car[n - k]) led = 1'b1;
      return {an, seg, dp, led};
   endfunction

   // Expected outputs of the NDIG=1, SCAN_DIV=2, STRETCH=1 instance after edge n.
   function automatic logic [9:0] exp_edge(input int n);
      int s, f;
      logic [3:0] snap;
      logic       sdp;
      s    = n - 1;
      f    = s / 2;
      snap = (f == 0) ? 4'h0 : he_dig[f * 2];
      sdp  = (f == 0) ? 1'b0 : he_dp[f * 2];
      return {((s % 2) == 0) ? 1'b1 : 1'b0, SEG_TAB[snap], ~sdp, he_car[n]};
   endfunction

   task automatic drive_idle();
      m_if.digits   = 16'h0000;
      m_if.dp_in    = 4'h0;
      m_if.blank_lz = 1'b0;
      m_if.carry_in = 4'h0;
      e_if.digits   = 4'h0;
      e_if.dp_in    = 1'b0;
      e_if.blank_lz = 1'b0;
      e_if.carry_in = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_main got=%h exp=%h", {m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
      n_checks++;
      if ({e_if.an_n, e_if.seg_n, e_if.dp_n, e_if.carry_led} !== {1'b1, 7'h7F, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_edge got=%h exp=%h", {e_if.an_n, e_if.seg_n, e_if.dp_n, e_if.carry_led}, {1'b1, 7'h7F, 1'b1, 1'b0});
      end
      rst = 1'b0;
      for (int c = 0; c < 3 * L; c++) begin
         @(negedge clk);
         n_checks++;
         if ({m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led} !== exp_main(m_n)) begin
            n_fail++;
            $display("FAIL scan_after_reset cyc=%0d got=%h exp=%h", m_n, {m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led}, exp_main(m_n));
         end
      end
   endtask

   task automatic test_blank_dp();
      m_if.digits   = 16'h03A7;
      m_if.dp_in    = 4'b0010;
      m_if.blank_lz = 1'b1;
      for (int c = 0; c < 3 * L; c++) begin
         @(negedge clk);
         n_checks++;
         if ({m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led} !== exp_main(m_n)) begin
            n_fail++;
            $display("FAIL blank_dp cyc=%0d got=%h exp=%h", m_n, {m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led}, exp_main(m_n));
         end
      end
      m_if.blank_lz = 1'b0;
      m_if.dp_in    = 4'h0;
   endtask

   task automatic test_snapshot();
      bit found = 1'b0;
      m_if.digits = 16'h1111;
      for (int c = 0; c < 4 * L; c++) begin
         @(negedge clk);
         n_checks++;
         if ({m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led} !== exp_main(m_n)) begin
            n_fail++;
            $display("FAIL snapshot_pre cyc=%0d got=%h exp=%h", m_n, {m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led}, exp_main(m_n));
         end
         if (c >= L && ((m_n / SD) % ND) == 1 && (m_n % SD) == 1) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL snapshot_wait got=timeout exp=idx1");
      end
      m_if.digits = 16'h2222;
      for (int c = 0; c < 2 * L; c++) begin
         @(negedge clk);
         n_checks++;
         if ({m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led} !== exp_main(m_n)) begin
            n_fail++;
            $display("FAIL snapshot_tear cyc=%0d got=%h exp=%h", m_n, {m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led}, exp_main(m_n));
         end
      end
   endtask

   task automatic test_carry();
      for (int c = 0; c < 28; c++) begin
         @(negedge clk);
         n_checks++;
         if ({m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led} !== exp_main(m_n)) begin
            n_fail++;
            $display("FAIL carry_stretch cyc=%0d got=%h exp=%h", m_n, {m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led}, exp_main(m_n));
         end
         m_if.carry_in = (c == 2) ? 4'b0100 : (c == 7) ? 4'b0001 : (c == 18) ? 4'b1011 : 4'b0000;
      end
   endtask

   task automatic test_random();
      logic [15:0] d;
      for (int c = 0; c < 320; c++) begin
         @(negedge clk);
         n_checks++;
         if ({m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led} !== exp_main(m_n)) begin
            n_fail++;
            $display("FAIL random cyc=%0d got=%h exp=%h", m_n, {m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led}, exp_main(m_n));
         end
         if ($urandom_range(0, 5) == 0) begin
            d = 16'h0000;
            for (int i = 0; i < ND; i++)
               d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            m_if.digits = d;
            m_if.dp_in  = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 15) == 0) m_if.blank_lz = ~m_if.blank_lz;
         m_if.carry_in = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      m_if.carry_in = 4'h0;
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      m_if.digits = 16'h5678;
      for (int c = 0; c < 4 * L; c++) begin
         @(negedge clk);
         if (c >= L && (m_n % SD) == 2 && ((m_n / SD) % ND) == 2) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL reset_mid_wait got=timeout exp=idx2");
      end
      m_if.carry_in = 4'b0001;
      @(negedge clk);
      m_if.carry_in = 4'b0000;
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_async got=%h exp=%h", {m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 2 * L; c++) begin
         @(negedge clk);
         n_checks++;
         if ({m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led} !== exp_main(m_n)) begin
            n_fail++;
            $display("FAIL reset_mid_restart cyc=%0d got=%h exp=%h", m_n, {m_if.an_n, m_if.seg_n, m_if.dp_n, m_if.carry_led}, exp_main(m_n));
         end
      end
   endtask

   task automatic test_edge_params();
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         n_checks++;
         if ({e_if.an_n, e_if.seg_n, e_if.dp_n, e_if.carry_led} !== exp_edge(e_n)) begin
            n_fail++;
            $display("FAIL edge_params cyc=%0d got=%h exp=%h", e_n, {e_if.an_n, e_if.seg_n, e_if.dp_n, e_if.carry_led}, exp_edge(e_n));
         end
         if ($urandom_range(0, 2) == 0) e_if.digits = 4'($urandom_range(0, 15));
         e_if.dp_in    = 1'($urandom_range(0, 1));
         e_if.carry_in = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_blank_dp();
      test_snapshot();
      test_carry();
      test_random();
      test_reset_mid();
      test_edge_params();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
